sr_ff_driver: RTL

- Drives a bank of WIDTH external SR flip-flops: accepts target words over a valid/ready interface and generates per-bit S/R excitation from a shadow copy of the bank state.
- Never emits S=R=1. Reads back q/q_bar one cycle after each drive and flags mismatches.
- Sits on the write side of SR storage cells: it is the sequencer that feeds their s/r inputs and checks their outputs.

---
 rtl/sr_ff_driver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sr_ff_driver.sv
// Sequencer for a bank of external SR flip-flops: turns target words into
// per-bit set/reset pulses from a shadow copy and verifies q/q_bar afterwards.
module sr_ff_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_fb,
  input  logic [WIDTH-1:0] q_fb_bar,
  output logic             done,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  typedef enum logic [2:0] {
    INIT,
    INIT_CHK,
    IDLE,
    DRIVE,
    CHECK
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shadow, shadow_d;
  logic [WIDTH-1:0] target, target_d;
  logic [WIDTH-1:0] s_d, r_d;
  logic [WIDTH-1:0] exp_q;
  logic [CNT_W-1:0] count_d;
  logic             done_d, err_d;
  logic             chk, mismatch;

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Excitation is only ever non-zero for one cycle (INIT or DRIVE), and the
  // set/reset terms come from disjoint masks, so s&r can never both be high.
  always_comb begin
    state_d  = state;
    s_d      = '0;
    r_d      = '0;
    shadow_d = shadow;
    target_d = target;
    done_d   = 1'b0;
    chk      = 1'b0;
    exp_q    = '0;

    case (state)
      INIT: begin
        state_d = INIT_CHK;
      end
      INIT_CHK: begin
        chk      = 1'b1;
        exp_q    = '0;
        shadow_d = q_fb;
        state_d  = IDLE;
      end
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          target_d = tgt_data;
          s_d      = tgt_data & ~shadow;
          r_d      = ~tgt_data & shadow;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        chk      = 1'b1;
        exp_q    = target;
        shadow_d = q_fb;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        r_d     = '1;
        state_d = INIT;
      end
    endcase

    mismatch = chk && ((q_fb != exp_q) || (q_fb_bar != ~exp_q));

    // A mismatch on the same edge as err_clr restarts the count at one.
    err_d   = err;
    count_d = err_count;
    if (mismatch) begin
      err_d   = 1'b1;
      if (err_clr) begin
        count_d = CNT_W'(1);
      end else if (&err_count) begin
        count_d = err_count;
      end else begin
        count_d = err_count + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_d   = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      s_out     <= '0;
      r_out     <= '1;
      shadow    <= '0;
      target    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      s_out     <= s_d;
      r_out     <= r_d;
      shadow    <= shadow_d;
      target    <= target_d;
      done      <= done_d;
      err       <= err_d;
      err_count <= count_d;
    end
  end

endmodule
